// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video pattern generator and the video receiver
// blocks:
//   - default raster timing (1080p-style line/frame totals)
//   - blanking levels for 10-bit Y and C
//   - 75% colour-bar Y/Cb/Cr table (8 bars, 240 samples wide each)
//   - interleave_yc(): packs 10-bit Y and C as {Y9,C9,Y8,C8,...,Y0,C0}
// -----------------------------------------------------------------------------
package video_pkg;

    localparam int unsigned H_ACTIVE_DEF = 1920;
    localparam int unsigned H_TOTAL_DEF  = 2200;
    localparam int unsigned V_BLANK_DEF  = 45;
    localparam int unsigned V_TOTAL_DEF  = 1125;

    localparam logic [9:0] BLANK_Y = 10'd64;
    localparam logic [9:0] BLANK_C = 10'd512;

    localparam int unsigned BAR_WIDTH = 240;
    localparam int unsigned NUM_BARS  = 8;

    typedef enum logic {
        PAT_BARS = 1'b0,
        PAT_FLAT = 1'b1
    } pattern_e;

    typedef struct packed {
        logic [9:0] y;
        logic [9:0] cb;
        logic [9:0] cr;
    } ycbcr_t;

    // Entry 0 is the leftmost bar; each entry is {Y, Cb, Cr}.
    localparam logic [NUM_BARS-1:0][29:0] BAR_TABLE = {
        {10'd64,  10'd512, 10'd512},
        {10'd111, 10'd848, 10'd481},
        {10'd204, 10'd435, 10'd848},
        {10'd251, 10'd771, 10'd817},
        {10'd534, 10'd253, 10'd207},
        {10'd581, 10'd589, 10'd176},
        {10'd674, 10'd176, 10'd543},
        {10'd721, 10'd512, 10'd512}
    };

    function automatic logic [19:0] interleave_yc(input logic [9:0] y,
                                                  input logic [9:0] c);
        logic [19:0] w;
        w = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            w[2*i+1] = y[i];
            w[2*i]   = c[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// -----------------------------------------------------------------------------
// video_timing_cnt
// Horizontal/vertical raster counters with combinational F/V/H/T/sof decode of
// the current counter state. The parent registers the decode, giving a single
// cen-cycle latency from counter state to outputs.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset (h=H_ACTIVE, v=V_TOTAL-1)
//   cen_i     clock enable; counters advance only when high
//   h_odd     LSB of the horizontal count (Cb/Cr phase)
//   line_end  h count is at its last sample of the line
//   fvht      {F, V, H, T} for the current counter state
//   sof       current counter state is sample 0 of line 0
// -----------------------------------------------------------------------------
module video_timing_cnt
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
    parameter int unsigned V_BLANK  = V_BLANK_DEF,
    parameter int unsigned V_TOTAL  = V_TOTAL_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cen_i,
    output logic       h_odd,
    output logic       line_end,
    output logic [3:0] fvht,
    output logic       sof
);

    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt <= HW'(H_ACTIVE);
            v_cnt <= VW'(V_TOTAL - 1);
        end else if (cen_i) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    always_comb begin
        line_end = (h_cnt == HW'(H_TOTAL - 1));
        h_odd    = h_cnt[0];
        fvht[3]  = 1'b0;
        fvht[2]  = (v_cnt < VW'(V_BLANK));
        fvht[1]  = (h_cnt >= HW'(H_ACTIVE));
        fvht[0]  = (h_cnt == '0) || (h_cnt == HW'(H_ACTIVE));
        sof      = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/video_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_pattern_gen
// Test-pattern source: 75% colour bars or a flat field, with embedded
// F/V/H/T timing and a start-of-frame pulse. All outputs are registered and
// lag the raster counters by one enabled cycle.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   cen_i          clock enable; all state and outputs hold while low
//   pattern_sel_i  0 = colour bars, 1 = flat field (latched at frame start)
//   flat_ycbcr_i   flat-field colour {Y, Cb, Cr} (latched at frame start)
//   fvht_o         timing {F, V, H, T}
//   video_o        interleaved {Y9,C9,...,Y0,C0}
//   sof_o          one enabled-cycle pulse on sample 0 of line 0
// -----------------------------------------------------------------------------
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
    parameter int unsigned V_BLANK  = V_BLANK_DEF,
    parameter int unsigned V_TOTAL  = V_TOTAL_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cen_i,
    input  logic        pattern_sel_i,
    input  logic [29:0] flat_ycbcr_i,
    output logic [3:0]  fvht_o,
    output logic [19:0] video_o,
    output logic        sof_o
);

    logic       h_odd;
    logic       line_end;
    logic [3:0] fvht_next;
    logic       sof_next;

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_BLANK  (V_BLANK),
        .V_TOTAL  (V_TOTAL)
    ) u_timing (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .cen_i    (cen_i),
        .h_odd    (h_odd),
        .line_end (line_end),
        .fvht     (fvht_next),
        .sof      (sof_next)
    );

    // Pattern controls are captured only at frame start so a frame is never
    // split between two patterns.
    pattern_e pat_q;
    ycbcr_t   flat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pat_q  <= PAT_BARS;
            flat_q <= '0;
        end else if (cen_i && sof_next) begin
            pat_q  <= pattern_e'(pattern_sel_i);
            flat_q <= ycbcr_t'(flat_ycbcr_i);
        end
    end

    // Bar index tracks h_cnt/BAR_WIDTH without a divider: a 0..BAR_WIDTH-1
    // sub-counter steps the index, both realigned to zero at line start.
    // The index saturates on the last bar; samples past it are blanking.
    logic [7:0] bar_sub;
    logic [2:0] bar_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bar_sub <= '0;
            bar_idx <= '0;
        end else if (cen_i) begin
            if (line_end) begin
                bar_sub <= '0;
                bar_idx <= '0;
            end else if (bar_sub == 8'(BAR_WIDTH - 1)) begin
                bar_sub <= '0;
                if (bar_idx != 3'(NUM_BARS - 1)) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_sub <= bar_sub + 8'd1;
            end
        end
    end

    ycbcr_t     px;
    logic [9:0] y_next;
    logic [9:0] c_next;

    always_comb begin
        px     = (pat_q == PAT_FLAT) ? flat_q : ycbcr_t'(BAR_TABLE[bar_idx]);
        y_next = px.y;
        c_next = h_odd ? px.cr : px.cb;
        if (fvht_next[2] || fvht_next[1]) begin
            y_next = BLANK_Y;
            c_next = BLANK_C;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fvht_o  <= 4'b0010;
            video_o <= interleave_yc(BLANK_Y, BLANK_C);
            sof_o   <= 1'b0;
        end else if (cen_i) begin
            fvht_o  <= fvht_next;
            video_o <= interleave_yc(y_next, c_next);
            sof_o   <= sof_next;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
module tb_video_pattern_gen;

    localparam int H_ACTIVE = 1920;
    localparam int H_TOTAL  = 2200;
    localparam int V_BLANK  = 2;
    localparam int V_TOTAL  = 5;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    // Linear raster position (v*H_TOTAL + h) that reset loads.
    localparam int START    = (V_TOTAL - 1) * H_TOTAL + H_ACTIVE;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        pattern_sel;
    logic [29:0] flat;
    logic [3:0]  fvht;
    logic [19:0] video;
    logic        sof;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_BLANK  (V_BLANK),
        .V_TOTAL  (V_TOTAL)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cen_i         (cen),
        .pattern_sel_i (pattern_sel),
        .flat_ycbcr_i  (flat),
        .fvht_o        (fvht),
        .video_o       (video),
        .sof_o         (sof)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    int bar_y  [8] = '{721, 674, 581, 534, 251, 204, 111, 64};
    int bar_cb [8] = '{512, 176, 589, 253, 771, 435, 848, 512};
    int bar_cr [8] = '{512, 543, 176, 207, 817, 848, 481, 512};

    // Reference model state: position of the raster for the next enabled edge.
    int pos;
    bit ref_valid = 1'b0;

    initial begin : monitor
        logic r, c, ps;
        logic [29:0] fl;
        int  h, v, b;
        int  m_pat, m_fy, m_fcb, m_fcr;
        int  exp_fvht, exp_y, exp_c, exp_sof;
        int  cur_h, cur_v;
        int  since_rst, hper_cnt, lines, vlines;
        bit  at_reset, advanced, vrise_armed, hper_valid, frame_started;
        bit  prev_h, prev_v, cur_hb, cur_vb;
        logic [9:0] dy, dc;
        m_pat = 0; m_fy = 0; m_fcb = 0; m_fcr = 0;
        exp_fvht = 0; exp_y = 0; exp_c = 0; exp_sof = 0;
        cur_h = 0; cur_v = 0; since_rst = 0; hper_cnt = 0; lines = 0; vlines = 0;
        vrise_armed = 0; hper_valid = 0; frame_started = 0; prev_h = 0; prev_v = 0;
        forever begin
            @(posedge clk);
            r = rst; c = cen; ps = pattern_sel; fl = flat;
            at_reset = 0; advanced = 0;
            if (r === 1'b1) begin
                ref_valid = 1; pos = START; m_pat = 0;
                exp_fvht = 4'b0010; exp_y = 64; exp_c = 512; exp_sof = 0;
                since_rst = 0; vrise_armed = 1; hper_valid = 0; hper_cnt = 0;
                frame_started = 0; prev_h = 1; prev_v = 0; at_reset = 1;
            end else if (c === 1'b1 && ref_valid) begin
                h = pos % H_TOTAL;
                v = pos / H_TOTAL;
                if (pos == 0) begin
                    m_pat = int'(ps);
                    m_fy = int'(fl[29:20]); m_fcb = int'(fl[19:10]); m_fcr = int'(fl[9:0]);
                end
                exp_fvht = ((v < V_BLANK) ? 4 : 0) + ((h >= H_ACTIVE) ? 2 : 0)
                         + ((h == 0 || h == H_ACTIVE) ? 1 : 0);
                exp_sof = (pos == 0) ? 1 : 0;
                if (h >= H_ACTIVE || v < V_BLANK) begin
                    exp_y = 64; exp_c = 512;
                end else if (m_pat == 1) begin
                    exp_y = m_fy; exp_c = (h % 2 == 1) ? m_fcr : m_fcb;
                end else begin
                    b = h / 240;
                    exp_y = bar_y[b]; exp_c = (h % 2 == 1) ? bar_cr[b] : bar_cb[b];
                end
                cur_h = h; cur_v = v;
                pos = (pos + 1) % FRAME;
                since_rst++;
                advanced = 1;
            end
            #1;
            if (ref_valid) begin
                for (int i = 0; i < 10; i++) begin
                    dy[i] = video[2*i+1];
                    dc[i] = video[2*i];
                end
                check("fvht", 32'(fvht), 32'(exp_fvht));
                check("sof", 32'(sof), 32'(exp_sof));
                check("video_y", 32'(dy), 32'(exp_y));
                check("video_c", 32'(dc), 32'(exp_c));
                if (at_reset) begin
                    check("reset_video_word", 32'(video), 32'h42000);
                    check("reset_fvht", 32'(fvht), 32'h2);
                    check("reset_sof", 32'(sof), 32'h0);
                end
                if (advanced) begin
                    cur_vb = fvht[2]; cur_hb = fvht[1];
                    if (since_rst == 1) check("first_sample_fvht", 32'(fvht), 32'h3);
                    if (vrise_armed && cur_vb && !prev_v) begin
                        check("vrise_delay", 32'(since_rst), 32'd281);
                        check("vrise_T", 32'(fvht[0]), 32'd1);
                        check("vrise_H", 32'(fvht[1]), 32'd0);
                        check("vrise_sof", 32'(sof), 32'd1);
                        vrise_armed = 0;
                    end
                    hper_cnt++;
                    if (prev_h && !cur_hb) begin
                        if (hper_valid) check("line_period", 32'(hper_cnt), 32'd2200);
                        hper_cnt = 0; hper_valid = 1;
                        if (sof) begin
                            if (frame_started) begin
                                check("lines_per_frame", 32'(lines), 32'd5);
                                check("vblank_lines", 32'(vlines), 32'd2);
                            end
                            lines = 0; vlines = 0; frame_started = 1;
                        end
                        lines++;
                        if (cur_vb) vlines++;
                    end
                    prev_h = cur_hb; prev_v = cur_vb;
                    if (m_pat == 0 && cur_v == V_BLANK) begin
                        if (cur_h == 0) begin
                            check("bar0_y", 32'(dy), 32'd721);
                            check("bar0_c", 32'(dc), 32'd512);
                        end
                        if (cur_h == 240) begin
                            check("bar1_y", 32'(dy), 32'd674);
                            check("bar1_cb", 32'(dc), 32'd176);
                        end
                        if (cur_h == 241) check("bar1_cr", 32'(dc), 32'd543);
                        if (cur_h == 1919) check("bar7_last_y", 32'(dy), 32'd64);
                    end
                    if (m_pat == 1 && m_fy == 940 && m_fcb == 512 && m_fcr == 512
                        && cur_v == V_BLANK && cur_h == 0) begin
                        check("flat_y", 32'(dy), 32'd940);
                        check("flat_c", 32'(dc), 32'd512);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bit found;
        rst = 1'b1; cen = 1'b0; pattern_sel = 1'b0; flat = '0;
        repeat (3) @(negedge clk);
        cen = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Bars frame; flat input wanders but must be ignored.
        repeat (281 + 3 * H_TOTAL + 500) begin
            @(negedge clk);
            flat = 30'($urandom);
        end
        // Mid-frame switch to flat white: takes effect next frame.
        pattern_sel = 1'b1;
        flat = {10'd940, 10'd512, 10'd512};
        repeat (2 * FRAME) @(negedge clk);

        // Random clock enable with occasional control changes.
        repeat (20000) begin
            @(negedge clk);
            cen = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                pattern_sel = 1'($urandom);
                flat = 30'($urandom);
            end
        end

        // Reset mid-line at h=1000 of line 3.
        cen = 1'b1;
        found = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (pos == 3 * H_TOTAL + 1000) begin
                found = 1;
                break;
            end
        end
        if (!found) check("reset_target_reached", 32'd0, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pattern_sel = 1'b0;
        repeat (FRAME + 500) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
